// File: rtl/amber_dmem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : amber_dmem_arb_if
// Purpose  : Bundles the core, debug and dmem-macro signals that connect to
//            the amber data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface amber_dmem_arb_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24
);
  // Core memory-access stage requester
  logic                  iw_core_req;
  logic                  iw_core_we;
  logic [ADDR_WIDTH-1:0] iw_core_addr;
  logic [DATA_WIDTH-1:0] iw_core_wdata;
  logic                  ow_core_gnt;
  logic                  ow_core_stall;
  logic                  or_core_rvalid;
  logic [DATA_WIDTH-1:0] ow_core_rdata;

  // Debug port requester and halt control
  logic                  iw_dbg_req;
  logic                  iw_dbg_we;
  logic [ADDR_WIDTH-1:0] iw_dbg_addr;
  logic [DATA_WIDTH-1:0] iw_dbg_wdata;
  logic                  ow_dbg_gnt;
  logic                  or_dbg_rvalid;
  logic [DATA_WIDTH-1:0] ow_dbg_rdata;
  logic                  iw_dbg_halt;
  logic                  or_halted;

  // Single-port dmem macro
  logic                  ow_mem_en;
  logic                  ow_mem_we;
  logic [ADDR_WIDTH-1:0] ow_mem_addr;
  logic [DATA_WIDTH-1:0] ow_mem_wdata;
  logic [DATA_WIDTH-1:0] iw_mem_rdata;

  // Arbiter side
  modport slave (
    input  iw_core_req, iw_core_we, iw_core_addr, iw_core_wdata,
    output ow_core_gnt, ow_core_stall, or_core_rvalid, ow_core_rdata,
    input  iw_dbg_req, iw_dbg_we, iw_dbg_addr, iw_dbg_wdata, iw_dbg_halt,
    output ow_dbg_gnt, or_dbg_rvalid, ow_dbg_rdata, or_halted,
    output ow_mem_en, ow_mem_we, ow_mem_addr, ow_mem_wdata,
    input  iw_mem_rdata
  );

  // Requester / memory side
  modport master (
    output iw_core_req, iw_core_we, iw_core_addr, iw_core_wdata,
    input  ow_core_gnt, ow_core_stall, or_core_rvalid, ow_core_rdata,
    output iw_dbg_req, iw_dbg_we, iw_dbg_addr, iw_dbg_wdata, iw_dbg_halt,
    input  ow_dbg_gnt, or_dbg_rvalid, ow_dbg_rdata, or_halted,
    input  ow_mem_en, ow_mem_we, ow_mem_addr, ow_mem_wdata,
    output iw_mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/amber_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : amber_dmem_arb
// Purpose  : Arbitrates the single-port dmem between the core MA stage and the
//            debug port, sequences debug halt, and routes 1-cycle read data
//            back to the requester that issued the read.
// Revision : 1.0 - initial release
// ============================================================================
module amber_dmem_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24,
  parameter int MAX_WAIT   = 4
) (
  input  wire logic        iw_clk,
  input  wire logic        iw_rst_n,
  amber_dmem_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state_q, state_d;
  owner_t     rd_owner_q, rd_owner_d;
  logic [3:0] wait_q, wait_d;

  logic core_gnt;
  logic dbg_gnt;
  logic core_req_eff;

  // Grant selection; the core only competes while running and not being halted
  always_comb begin
    core_gnt     = 1'b0;
    dbg_gnt      = 1'b0;
    core_req_eff = bus.iw_core_req & (state_q == ST_RUN) & ~bus.iw_dbg_halt;
    if (iw_rst_n) begin
      if (state_q == ST_RUN) begin
        dbg_gnt  = bus.iw_dbg_req & (~core_req_eff | (wait_q >= MAX_WAIT_C));
        core_gnt = core_req_eff & ~dbg_gnt;
      end else begin
        dbg_gnt  = bus.iw_dbg_req;
      end
    end
  end

  // Next-state for halt FSM, starvation counter and read-owner tracking
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    rd_owner_d = OWN_NONE;

    case (state_q)
      ST_RUN:    if (bus.iw_dbg_halt) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.iw_dbg_halt)            state_d = ST_RUN;
        else if (rd_owner_q != OWN_CORE) state_d = ST_HALTED;
      end
      ST_HALTED: if (!bus.iw_dbg_halt) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    if (dbg_gnt || !bus.iw_dbg_req) wait_d = 4'd0;
    else if (wait_q < MAX_WAIT_C)   wait_d = wait_q + 4'd1;

    if (core_gnt && !bus.iw_core_we)     rd_owner_d = OWN_CORE;
    else if (dbg_gnt && !bus.iw_dbg_we)  rd_owner_d = OWN_DBG;
  end

  // State registers; reset also drops any read still in flight
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_q    <= ST_RUN;
      wait_q     <= 4'd0;
      rd_owner_q <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Memory drive muxed from the granted requester, zero when idle
  always_comb begin
    bus.ow_mem_en    = core_gnt | dbg_gnt;
    bus.ow_mem_we    = 1'b0;
    bus.ow_mem_addr  = '0;
    bus.ow_mem_wdata = '0;
    if (dbg_gnt) begin
      bus.ow_mem_we    = bus.iw_dbg_we;
      bus.ow_mem_addr  = bus.iw_dbg_addr;
      bus.ow_mem_wdata = bus.iw_dbg_wdata;
    end else if (core_gnt) begin
      bus.ow_mem_we    = bus.iw_core_we;
      bus.ow_mem_addr  = bus.iw_core_addr;
      bus.ow_mem_wdata = bus.iw_core_wdata;
    end
  end

  // Requester-facing outputs; read data is gated to the owner of the read
  always_comb begin
    bus.ow_core_gnt    = core_gnt;
    bus.ow_core_stall  = bus.iw_core_req & ~core_gnt;
    bus.ow_dbg_gnt     = dbg_gnt;
    bus.or_core_rvalid = (rd_owner_q == OWN_CORE);
    bus.or_dbg_rvalid  = (rd_owner_q == OWN_DBG);
    bus.ow_core_rdata  = bus.or_core_rvalid ? bus.iw_mem_rdata : '0;
    bus.ow_dbg_rdata   = bus.or_dbg_rvalid  ? bus.iw_mem_rdata : '0;
    bus.or_halted      = (state_q == ST_HALTED);
  end

endmodule
`default_nettype wire

// File: tb/tb_amber_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_amber_dmem_arb
// Purpose  : Self-checking bench for amber_dmem_arb with a dmem model and
//            per-requester read-data scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_amber_dmem_arb;
  localparam int AW = 12;
  localparam int DW = 24;
  localparam int MW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [DW-1:0] mem     [4096];
  logic [DW-1:0] ref_mem [4096];
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] exp_core_q [$];
  logic [DW-1:0] exp_dbg_q  [$];
  logic [DW-1:0] exp;

  amber_dmem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  amber_dmem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .iw_clk   (clk),
    .iw_rst_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // dmem model: one-cycle read latency, write on the enabled edge
  always @(posedge clk) begin
    if (bus.ow_mem_en) begin
      if (bus.ow_mem_we) mem[bus.ow_mem_addr] <= bus.ow_mem_wdata;
      else               mem_rdata <= mem[bus.ow_mem_addr];
    end
  end
  assign bus.iw_mem_rdata = mem_rdata;

  function automatic logic [DW-1:0] pat(input int a);
    logic [11:0] x;
    x = a[11:0];
    return {x, ~x};
  endfunction

  task automatic core_drive(input logic req, input logic we, input int addr, input logic [DW-1:0] wd);
    bus.iw_core_req   = req;
    bus.iw_core_we    = we;
    bus.iw_core_addr  = AW'(addr);
    bus.iw_core_wdata = wd;
  endtask

  task automatic dbg_drive(input logic req, input logic we, input int addr, input logic [DW-1:0] wd);
    bus.iw_dbg_req   = req;
    bus.iw_dbg_we    = we;
    bus.iw_dbg_addr  = AW'(addr);
    bus.iw_dbg_wdata = wd;
  endtask

  task automatic idle();
    core_drive(1'b0, 1'b0, 0, '0);
    dbg_drive(1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    core_drive(1'b1, 1'b0, 12'h055, '0);
    dbg_drive(1'b1, 1'b1, 12'h066, 24'h111111);
    bus.iw_dbg_halt = 1'b0;
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b0 || bus.ow_dbg_gnt !== 1'b0 || bus.ow_mem_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_grants: core_gnt=%b dbg_gnt=%b mem_en=%b, want 0/0/0",
               bus.ow_core_gnt, bus.ow_dbg_gnt, bus.ow_mem_en);
    end
    tests++;
    if (bus.or_core_rvalid !== 1'b0 || bus.or_dbg_rvalid !== 1'b0 || bus.or_halted !== 1'b0 ||
        bus.ow_core_rdata !== '0 || bus.ow_dbg_rdata !== '0 || bus.ow_mem_addr !== '0) begin
      fails++;
      $display("FAIL reset_regs: crv=%b drv=%b halted=%b crd=%h drd=%h maddr=%h, want all 0",
               bus.or_core_rvalid, bus.or_dbg_rvalid, bus.or_halted,
               bus.ow_core_rdata, bus.ow_dbg_rdata, bus.ow_mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #2;
    tests++;
    if (bus.ow_core_stall !== 1'b0 || bus.ow_mem_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: stall=%b mem_en=%b, want 0/0", bus.ow_core_stall, bus.ow_mem_en);
    end
  endtask

  task automatic test_core_read();
    @(negedge clk);
    core_drive(1'b1, 1'b0, 12'h010, '0);
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b1 || bus.ow_mem_en !== 1'b1 || bus.ow_mem_we !== 1'b0 ||
        bus.ow_mem_addr !== 12'h010 || bus.ow_core_stall !== 1'b0) begin
      fails++;
      $display("FAIL core_rd_issue: gnt=%b en=%b we=%b addr=%h stall=%b, want 1/1/0/010/0",
               bus.ow_core_gnt, bus.ow_mem_en, bus.ow_mem_we, bus.ow_mem_addr, bus.ow_core_stall);
    end
    exp_core_q.push_back(ref_mem[12'h010]);
    @(negedge clk);
    idle();
    #2;
    tests++;
    if (bus.or_core_rvalid !== 1'b1) begin
      fails++;
      $display("FAIL core_rd_rvalid: got %b want 1", bus.or_core_rvalid);
    end
    exp = exp_core_q.pop_front();
    tests++;
    if (bus.ow_core_rdata !== exp) begin
      fails++;
      $display("FAIL core_rd_data: got %h want %h", bus.ow_core_rdata, exp);
    end
    tests++;
    if (bus.or_dbg_rvalid !== 1'b0 || bus.ow_dbg_rdata !== '0 || bus.ow_dbg_gnt !== 1'b0) begin
      fails++;
      $display("FAIL core_rd_dbg_quiet: drv=%b drd=%h dgnt=%b want 0/0/0",
               bus.or_dbg_rvalid, bus.ow_dbg_rdata, bus.ow_dbg_gnt);
    end
  endtask

  task automatic test_contention();
    bit dbg_exp;
    bit prev_core;
    bit prev_dbg;
    prev_core = 1'b0;
    prev_dbg  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      core_drive(1'b1, 1'b0, 12'h100 + c, '0);
      dbg_drive(1'b1, 1'b0, 12'hFF8, '0);
      #2;
      dbg_exp = (c == 4 || c == 9);
      tests++;
      if (bus.ow_dbg_gnt !== dbg_exp || bus.ow_core_gnt !== ~dbg_exp || bus.ow_core_stall !== dbg_exp) begin
        fails++;
        $display("FAIL contend_arb c=%0d: dgnt=%b cgnt=%b stall=%b, want %b/%b/%b",
                 c, bus.ow_dbg_gnt, bus.ow_core_gnt, bus.ow_core_stall, dbg_exp, ~dbg_exp, dbg_exp);
      end
      if (dbg_exp) begin
        tests++;
        if (bus.ow_mem_addr !== 12'hFF8) begin
          fails++;
          $display("FAIL contend_addr c=%0d: got %h want ff8", c, bus.ow_mem_addr);
        end
        exp_dbg_q.push_back(ref_mem[12'hFF8]);
      end else begin
        exp_core_q.push_back(ref_mem[12'h100 + c]);
      end
      if (c > 0) begin
        tests++;
        if (bus.or_core_rvalid !== prev_core || bus.or_dbg_rvalid !== prev_dbg) begin
          fails++;
          $display("FAIL contend_rvalid c=%0d: crv=%b drv=%b want %b/%b",
                   c, bus.or_core_rvalid, bus.or_dbg_rvalid, prev_core, prev_dbg);
        end
        if (prev_core) begin
          exp = exp_core_q.pop_front();
          tests++;
          if (bus.ow_core_rdata !== exp) begin
            fails++;
            $display("FAIL contend_cdata c=%0d: got %h want %h", c, bus.ow_core_rdata, exp);
          end
        end
        if (prev_dbg) begin
          exp = exp_dbg_q.pop_front();
          tests++;
          if (bus.ow_dbg_rdata !== exp) begin
            fails++;
            $display("FAIL contend_ddata c=%0d: got %h want %h", c, bus.ow_dbg_rdata, exp);
          end
        end
      end
      prev_core = ~dbg_exp;
      prev_dbg  = dbg_exp;
    end
    @(negedge clk);
    idle();
    #2;
    exp = exp_dbg_q.pop_front();
    tests++;
    if (bus.or_dbg_rvalid !== 1'b1 || bus.ow_dbg_rdata !== exp) begin
      fails++;
      $display("FAIL contend_last: drv=%b data=%h want 1/%h", bus.or_dbg_rvalid, bus.ow_dbg_rdata, exp);
    end
  endtask

  task automatic test_halt_resume();
    @(negedge clk);
    core_drive(1'b1, 1'b0, 12'h020, '0);
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b1) begin
      fails++;
      $display("FAIL halt_pre_gnt: got %b want 1", bus.ow_core_gnt);
    end
    exp_core_q.push_back(ref_mem[12'h020]);
    // cycle N: halt requested, read from N-1 still returns
    @(negedge clk);
    bus.iw_dbg_halt = 1'b1;
    core_drive(1'b1, 1'b0, 12'h021, '0);
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b0 || bus.ow_core_stall !== 1'b1 || bus.or_halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_n: cgnt=%b stall=%b halted=%b want 0/1/0",
               bus.ow_core_gnt, bus.ow_core_stall, bus.or_halted);
    end
    exp = exp_core_q.pop_front();
    tests++;
    if (bus.or_core_rvalid !== 1'b1 || bus.ow_core_rdata !== exp) begin
      fails++;
      $display("FAIL halt_drain_rd: crv=%b data=%h want 1/%h", bus.or_core_rvalid, bus.ow_core_rdata, exp);
    end
    // cycle N+1: draining, not yet halted
    @(negedge clk);
    #2;
    tests++;
    if (bus.or_halted !== 1'b0 || bus.ow_core_gnt !== 1'b0 || bus.or_core_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL halt_n1: halted=%b cgnt=%b crv=%b want 0/0/0",
               bus.or_halted, bus.ow_core_gnt, bus.or_core_rvalid);
    end
    // cycle N+2: halted, debug write
    @(negedge clk);
    dbg_drive(1'b1, 1'b1, 12'h007, 24'hABCDEF);
    #2;
    tests++;
    if (bus.or_halted !== 1'b1 || bus.ow_core_stall !== 1'b1) begin
      fails++;
      $display("FAIL halt_n2: halted=%b stall=%b want 1/1", bus.or_halted, bus.ow_core_stall);
    end
    tests++;
    if (bus.ow_dbg_gnt !== 1'b1 || bus.ow_mem_we !== 1'b1 || bus.ow_mem_addr !== 12'h007 ||
        bus.ow_mem_wdata !== 24'hABCDEF) begin
      fails++;
      $display("FAIL halt_dbg_wr: dgnt=%b we=%b addr=%h wd=%h want 1/1/007/abcdef",
               bus.ow_dbg_gnt, bus.ow_mem_we, bus.ow_mem_addr, bus.ow_mem_wdata);
    end
    ref_mem[12'h007] = 24'hABCDEF;
    @(negedge clk);
    dbg_drive(1'b1, 1'b0, 12'h007, '0);
    #2;
    tests++;
    if (bus.ow_dbg_gnt !== 1'b1 || bus.or_dbg_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL halt_dbg_rd: dgnt=%b drv=%b want 1/0", bus.ow_dbg_gnt, bus.or_dbg_rvalid);
    end
    exp_dbg_q.push_back(ref_mem[12'h007]);
    @(negedge clk);
    dbg_drive(1'b0, 1'b0, 0, '0);
    #2;
    exp = exp_dbg_q.pop_front();
    tests++;
    if (bus.or_dbg_rvalid !== 1'b1 || bus.ow_dbg_rdata !== exp || bus.or_halted !== 1'b1) begin
      fails++;
      $display("FAIL halt_dbg_data: drv=%b data=%h halted=%b want 1/%h/1",
               bus.or_dbg_rvalid, bus.ow_dbg_rdata, bus.or_halted, exp);
    end
    // resume: halt drops while HALTED, core granted the following cycle
    @(negedge clk);
    bus.iw_dbg_halt = 1'b0;
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b0 || bus.or_halted !== 1'b1) begin
      fails++;
      $display("FAIL resume_drop: cgnt=%b halted=%b want 0/1", bus.ow_core_gnt, bus.or_halted);
    end
    @(negedge clk);
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b1 || bus.or_halted !== 1'b0 || bus.ow_mem_addr !== 12'h021) begin
      fails++;
      $display("FAIL resume_gnt: cgnt=%b halted=%b addr=%h want 1/0/021",
               bus.ow_core_gnt, bus.or_halted, bus.ow_mem_addr);
    end
    exp_core_q.push_back(ref_mem[12'h021]);
    @(negedge clk);
    idle();
    #2;
    exp = exp_core_q.pop_front();
    tests++;
    if (bus.or_core_rvalid !== 1'b1 || bus.ow_core_rdata !== exp) begin
      fails++;
      $display("FAIL resume_data: crv=%b data=%h want 1/%h", bus.or_core_rvalid, bus.ow_core_rdata, exp);
    end
  endtask

  task automatic test_back_to_back();
    // debug read, core write, core read of the written word
    @(negedge clk);
    dbg_drive(1'b1, 1'b0, 12'h030, '0);
    #2;
    tests++;
    if (bus.ow_dbg_gnt !== 1'b1 || bus.ow_mem_addr !== 12'h030) begin
      fails++;
      $display("FAIL b2b_dbg_issue: dgnt=%b addr=%h want 1/030", bus.ow_dbg_gnt, bus.ow_mem_addr);
    end
    exp_dbg_q.push_back(ref_mem[12'h030]);
    @(negedge clk);
    dbg_drive(1'b0, 1'b0, 0, '0);
    core_drive(1'b1, 1'b1, 12'h031, 24'h654321);
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b1 || bus.ow_mem_we !== 1'b1 || bus.ow_mem_wdata !== 24'h654321) begin
      fails++;
      $display("FAIL b2b_wr_issue: cgnt=%b we=%b wd=%h want 1/1/654321",
               bus.ow_core_gnt, bus.ow_mem_we, bus.ow_mem_wdata);
    end
    ref_mem[12'h031] = 24'h654321;
    exp = exp_dbg_q.pop_front();
    tests++;
    if (bus.or_dbg_rvalid !== 1'b1 || bus.ow_dbg_rdata !== exp || bus.or_core_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_dbg_data: drv=%b data=%h crv=%b want 1/%h/0",
               bus.or_dbg_rvalid, bus.ow_dbg_rdata, bus.or_core_rvalid, exp);
    end
    @(negedge clk);
    core_drive(1'b1, 1'b0, 12'h031, '0);
    #2;
    tests++;
    if (bus.or_core_rvalid !== 1'b0 || bus.or_dbg_rvalid !== 1'b0 || bus.ow_core_gnt !== 1'b1) begin
      fails++;
      $display("FAIL b2b_wr_norv: crv=%b drv=%b cgnt=%b want 0/0/1",
               bus.or_core_rvalid, bus.or_dbg_rvalid, bus.ow_core_gnt);
    end
    exp_core_q.push_back(ref_mem[12'h031]);
    @(negedge clk);
    idle();
    #2;
    exp = exp_core_q.pop_front();
    tests++;
    if (bus.or_core_rvalid !== 1'b1 || bus.ow_core_rdata !== exp) begin
      fails++;
      $display("FAIL b2b_core_data: crv=%b data=%h want 1/%h", bus.or_core_rvalid, bus.ow_core_rdata, exp);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    core_drive(1'b1, 1'b0, 12'h040, '0);
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_issue: got %b want 1", bus.ow_core_gnt);
    end
    @(negedge clk);
    rst_n = 1'b0;
    core_drive(1'b1, 1'b0, 12'h041, '0);
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b0 || bus.ow_mem_en !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_force: cgnt=%b en=%b want 0/0", bus.ow_core_gnt, bus.ow_mem_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #2;
    tests++;
    if (bus.or_core_rvalid !== 1'b0 || bus.or_dbg_rvalid !== 1'b0 || bus.ow_core_rdata !== '0 ||
        bus.or_halted !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_drop: crv=%b drv=%b crd=%h halted=%b want 0/0/0/0",
               bus.or_core_rvalid, bus.or_dbg_rvalid, bus.ow_core_rdata, bus.or_halted);
    end
    @(negedge clk);
    core_drive(1'b1, 1'b0, 12'h042, '0);
    #2;
    tests++;
    if (bus.ow_core_gnt !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_run: cgnt=%b want 1", bus.ow_core_gnt);
    end
    exp_core_q.push_back(ref_mem[12'h042]);
    @(negedge clk);
    idle();
    #2;
    exp = exp_core_q.pop_front();
    tests++;
    if (bus.or_core_rvalid !== 1'b1 || bus.ow_core_rdata !== exp) begin
      fails++;
      $display("FAIL rstmid_data: crv=%b data=%h want 1/%h", bus.or_core_rvalid, bus.ow_core_rdata, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = pat(i);
      ref_mem[i] = pat(i);
    end
    mem[12'h010]     = 24'h123456;
    ref_mem[12'h010] = 24'h123456;
    mem_rdata        = '0;
    bus.iw_dbg_halt  = 1'b0;
    idle();

    test_reset();
    test_core_read();
    test_contention();
    test_halt_resume();
    test_back_to_back();
    test_reset_mid();

    tests++;
    if (exp_core_q.size() != 0 || exp_dbg_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: core_left=%0d dbg_left=%0d want 0/0",
               exp_core_q.size(), exp_dbg_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
